// File: rtl/ts_packet_mux_if.sv
// Source/output-side signal bundle of the TS packet multiplexer.
// master = the multiplexer, slave = FIFO bank plus TS output consumer.
interface ts_packet_mux_if #(
    parameter int unsigned N_SRC = 4
);
    logic [N_SRC-1:0]   GOT_FULL_PACKET;
    logic [8*N_SRC-1:0] DATA_IN_BUS;
    logic [N_SRC-1:0]   RD_REQ;
    logic [7:0]         DATA_OUT;
    logic               D_VALID_OUT;
    logic               P_SYNC_OUT;
    logic               SYNC_ERR;
    logic [2:0]         ACTIVE_SRC;

    modport master (
        input  GOT_FULL_PACKET, DATA_IN_BUS,
        output RD_REQ, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR, ACTIVE_SRC
    );

    modport slave (
        output GOT_FULL_PACKET, DATA_IN_BUS,
        input  RD_REQ, DATA_OUT, D_VALID_OUT, P_SYNC_OUT, SYNC_ERR, ACTIVE_SRC
    );
endinterface

// File: rtl/ts_packet_mux.sv
// N-source round-robin TS packet multiplexer with SPI-programmable per-source headers.
// Optional null-frame fill when idle is enabled by defining TSMUX_NULL_FILL_EN.
module ts_packet_mux #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned HDR_LEN       = 4,
    parameter int unsigned PKT_LEN       = 188,
    parameter logic [7:0]  ADDR_HDR_BASE = 8'h20,
    parameter int unsigned NULL_TIMEOUT  = 64
) (
    input  logic               SYS_CLK,
    input  logic               RST,
    ts_packet_mux_if.master    ts,
    input  logic [7:0]         SPI_ADDRESS,
    input  logic [7:0]         SPI_DATA,
    input  logic               RISING_SS,
    output logic               DCLK_OUT
);

    localparam int unsigned SW        = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [8:0]  HDR_BASE  = {1'b0, ADDR_HDR_BASE};
    localparam logic [8:0]  MASK_ADDR = HDR_BASE + 9'(N_SRC * HDR_LEN);
    localparam logic [7:0]  HDR_LAST  = 8'(HDR_LEN - 1);
    localparam logic [7:0]  PKT_LAST  = 8'(PKT_LEN - 1);

    if (N_SRC < 2 || N_SRC > 8 || HDR_LEN < 1 || HDR_LEN > 8 ||
        (PKT_LEN != 188 && PKT_LEN != 204) || NULL_TIMEOUT < 1) begin : g_param_check
        $error("ts_packet_mux: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN,
        HEADER,
        PAYLOAD
    } state_t;

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [SW-1:0]    rr_ptr, rr_ptr_n;
    logic [SW-1:0]    active_src, active_src_n;
    logic [7:0]       hdr_mem  [N_SRC][HDR_LEN];
    logic [7:0]       hdr_snap [HDR_LEN];
    logic [N_SRC-1:0] mask;
    logic [8:0]       spi_addr9;

    logic [N_SRC-1:0] eligible;
    logic             found;
    logic [SW-1:0]    winner;
    logic [SW-1:0]    idx;

    logic             snap_load;
    logic             hdr_shift;
    logic             rd_en;
    logic             null_frame;
    logic             null_start;
    logic [7:0]       null_byte;
    logic [7:0]       src_byte;

    logic [N_SRC-1:0] rd_vec;
    logic [7:0]       dout;
    logic             valid;
    logic             psync;
    logic             serr;

    assign DCLK_OUT  = SYS_CLK;
    assign spi_addr9 = {1'b0, SPI_ADDRESS};

    // Header bytes and source mask; snapshot at arbitration reads the pre-write value.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned s = 0; s < N_SRC; s++) begin
                for (int unsigned b = 0; b < HDR_LEN; b++) begin
                    hdr_mem[s][b] <= (b == 0) ? 8'(s) : (b == 1) ? 8'(s + 2) : 8'h00;
                end
            end
            mask <= '1;
        end else if (RISING_SS) begin
            for (int unsigned s = 0; s < N_SRC; s++) begin
                for (int unsigned b = 0; b < HDR_LEN; b++) begin
                    if (spi_addr9 == HDR_BASE + 9'(s * HDR_LEN + b)) begin
                        hdr_mem[s][b] <= SPI_DATA;
                    end
                end
            end
            if (spi_addr9 == MASK_ADDR) begin
                mask <= SPI_DATA[N_SRC-1:0];
            end
        end
    end

    // Round-robin search starting at rr_ptr, wrapping at N_SRC.
    always_comb begin
        eligible = ts.GOT_FULL_PACKET & mask;
        found    = 1'b0;
        winner   = '0;
        idx      = rr_ptr;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == SW'(N_SRC - 1)) ? '0 : idx + SW'(1);
        end
    end

    always_comb begin
        src_byte = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (active_src == SW'(k)) begin
                src_byte = ts.DATA_IN_BUS[8*k +: 8];
            end
        end
    end

`ifdef TSMUX_NULL_FILL_EN
    localparam int unsigned TW = $clog2(NULL_TIMEOUT + 1);

    logic [TW-1:0] idle_tmr;

    assign null_start = (state == SCAN) && !found && (idle_tmr == TW'(NULL_TIMEOUT - 1));

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            idle_tmr   <= '0;
            null_frame <= 1'b0;
        end else begin
            if (state == SCAN && !found && !null_start) begin
                idle_tmr <= idle_tmr + TW'(1);
            end else begin
                idle_tmr <= '0;
            end
            if (null_start) begin
                null_frame <= 1'b1;
            end else if (snap_load) begin
                null_frame <= 1'b0;
            end
        end
    end

    always_comb begin
        case (cnt)
            8'd0:    null_byte = 8'h47;
            8'd1:    null_byte = 8'h1F;
            8'd2:    null_byte = 8'hFF;
            8'd3:    null_byte = 8'h10;
            default: null_byte = 8'hFF;
        endcase
    end
`else
    assign null_start = 1'b0;
    assign null_frame = 1'b0;
    assign null_byte  = 8'hFF;
`endif

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state      <= SCAN;
            cnt        <= '0;
            rr_ptr     <= '0;
            active_src <= '0;
            for (int unsigned j = 0; j < HDR_LEN; j++) begin
                hdr_snap[j] <= '0;
            end
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rr_ptr     <= rr_ptr_n;
            active_src <= active_src_n;
            if (snap_load) begin
                for (int unsigned j = 0; j < HDR_LEN; j++) begin
                    hdr_snap[j] <= hdr_mem[winner][j];
                end
            end else if (hdr_shift) begin
                for (int unsigned j = 0; j + 1 < HDR_LEN; j++) begin
                    hdr_snap[j] <= hdr_snap[j+1];
                end
            end
        end
    end

    // The FIFO read for payload byte j is issued one cycle ahead of its output,
    // so RD_REQ starts on the last header byte and stops before the last payload byte.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        rr_ptr_n     = rr_ptr;
        active_src_n = active_src;
        snap_load    = 1'b0;
        hdr_shift    = 1'b0;
        rd_en        = 1'b0;
        valid        = 1'b0;
        psync        = 1'b0;
        serr         = 1'b0;
        dout         = '0;
        case (state)
            SCAN: begin
                cnt_n = '0;
                if (found) begin
                    snap_load    = 1'b1;
                    active_src_n = winner;
                    rr_ptr_n     = (winner == SW'(N_SRC - 1)) ? '0 : winner + SW'(1);
                    state_n      = HEADER;
                end else if (null_start) begin
                    state_n = HEADER;
                end
            end
            HEADER: begin
                valid     = 1'b1;
                dout      = null_frame ? 8'hFF : hdr_snap[0];
                hdr_shift = 1'b1;
                if (cnt == HDR_LAST) begin
                    rd_en   = 1'b1;
                    cnt_n   = '0;
                    state_n = PAYLOAD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PAYLOAD: begin
                valid = 1'b1;
                dout  = null_frame ? null_byte : src_byte;
                if (cnt == 8'd0) begin
                    psync = 1'b1;
                    serr  = !null_frame && (src_byte != 8'h47);
                end
                if (cnt == PKT_LAST) begin
                    cnt_n   = '0;
                    state_n = SCAN;
                end else begin
                    rd_en = 1'b1;
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_comb begin
        rd_vec = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            rd_vec[k] = rd_en && !null_frame && (active_src == SW'(k));
        end
    end

    assign ts.RD_REQ      = rd_vec;
    assign ts.DATA_OUT    = dout;
    assign ts.D_VALID_OUT = valid;
    assign ts.P_SYNC_OUT  = psync;
    assign ts.SYNC_ERR    = serr;
    assign ts.ACTIVE_SRC  = 3'(active_src);

endmodule
